tm_tape_head: RTL and testbench

//  Head controller and write-port initiator for tm_tape_cache. Accepts one

---
 rtl/tm_tape_head.sv | 128 ++++++++++++
 tb/tb_tm_tape_head.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_tape_head.sv
// Tape head controller for tm_tape_cache: takes one write/move command at a time,
// runs the cache write-port 4-phase handshake, then steps the head modulo the window.
module tm_tape_head #(
  parameter int CACHE_BITS = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [7:0]            cmd_sym_i,
  input  logic [1:0]            cmd_move_i,
  output logic [CACHE_BITS-1:0] head_o,
  output logic [CACHE_BITS-1:0] rd_addr_o,
  input  logic [7:0]            rd_data_i,
  output logic [7:0]            sym_o,
  output logic                  wr_en_o,
  output logic [CACHE_BITS-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o,
  input  logic                  wr_done_i,
  output logic                  wrap_o,
  output logic                  wrap_left_o,
  output logic                  err_o
);

  localparam int                    TW       = $clog2(TIMEOUT + 1);
  localparam logic [CACHE_BITS-1:0] HEAD_MAX = '1;
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, REL, MOVE} state_t;

  state_t        state;
  logic [1:0]    move_q;
  logic [TW-1:0] timer;
  logic          ack_armed;
  logic          accept;

  assign cmd_ready_o = (state == IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign rd_addr_o   = head_o;
  assign sym_o       = rd_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      head_o      <= '0;
      move_q      <= 2'b00;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= 8'h00;
      wrap_o      <= 1'b0;
      wrap_left_o <= 1'b0;
      err_o       <= 1'b0;
      timer       <= '0;
      ack_armed   <= 1'b0;
    end else begin
      wrap_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            move_q    <= cmd_move_i;
            wr_addr_o <= head_o;
            wr_data_o <= cmd_sym_i;
            timer     <= '0;
            ack_armed <= 1'b0;
            if (cmd_wr_i) begin
              state   <= REQ;
              wr_en_o <= 1'b1;
            end else begin
              state   <= MOVE;
            end
          end
        end
        REQ: begin
          // An ack already high on entry is stale: only honour it after seeing it low here.
          if (wr_done_i && ack_armed) begin
            state   <= REL;
            wr_en_o <= 1'b0;
            timer   <= '0;
          end else if (timer == TMO_LAST) begin
            state   <= IDLE;
            wr_en_o <= 1'b0;
            err_o   <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
            if (!wr_done_i) ack_armed <= 1'b1;
          end
        end
        REL: begin
          if (!wr_done_i) begin
            state <= MOVE;
            timer <= '0;
          end else if (timer == TMO_LAST) begin
            state <= IDLE;
            err_o <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        MOVE: begin
          state <= IDLE;
          case (move_q)
            2'b01: begin
              head_o <= head_o + 1'b1;
              if (head_o == HEAD_MAX) begin
                wrap_o      <= 1'b1;
                wrap_left_o <= 1'b0;
              end
            end
            2'b10: begin
              head_o <= head_o - 1'b1;
              if (head_o == '0) begin
                wrap_o      <= 1'b1;
                wrap_left_o <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_tape_head.sv
// Bench for tm_tape_head: a tm_tape_cache write-port responder, a write scoreboard,
// a command vector table and hand-written timeout / stale-ack / reset sequences.
module tb_tm_tape_head;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [7:0] cmd_sym;
  logic [1:0] cmd_move;
  logic [2:0] head, rd_addr, wr_addr;
  logic [7:0] rd_data, sym, wr_data;
  logic       wr_en, wr_done, wrap, wrap_left, err;

  int checks = 0;
  int errors = 0;

  tm_tape_head dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_sym_i(cmd_sym), .cmd_move_i(cmd_move),
    .head_o(head), .rd_addr_o(rd_addr), .rd_data_i(rd_data), .sym_o(sym),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_done_i(wr_done),
    .wrap_o(wrap), .wrap_left_o(wrap_left), .err_o(err)
  );

  always #5 clk = ~clk;

  // Cache responder: sees wr_en, writes one edge later, holds done until wr_en drops.
  logic [7:0]  mem [8];
  logic [1:0]  cst;
  logic        stub_done;
  bit          no_ack = 1'b0;
  bit          force_done = 1'b0;
  logic [10:0] exp_q[$];
  logic [10:0] act_q[$];

  assign wr_done = stub_done | force_done;
  assign rd_data = mem[rd_addr];

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    cst = 2'd0;
    stub_done = 1'b0;
    forever begin
      @(posedge clk);
      if (!no_ack && !force_done) begin
        case (cst)
          2'd0: if (wr_en) cst <= 2'd1;
          2'd1: begin
            mem[wr_addr] <= wr_data;
            act_q.push_back({wr_addr, wr_data});
            stub_done <= 1'b1;
            cst <= 2'd2;
          end
          2'd2: if (!wr_en) begin stub_done <= 1'b0; cst <= 2'd0; end
          default: cst <= 2'd0;
        endcase
      end
    end
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void drain(string tag);
    logic [10:0] e, a;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      chk({tag, " cache write"}, int'(a), int'(e));
    end
    chk({tag, " unmatched writes"}, exp_q.size() + act_q.size(), 0);
    exp_q.delete();
    act_q.delete();
  endfunction

  // Issues one command; returns edges from accept until ready, wr_en-high samples, wrap pulses.
  task automatic run_cmd(input logic wr, input logic [7:0] s, input logic [1:0] mv,
                         input bit push, output int cyc, output int wrc, output int wpc);
    int n;
    logic [2:0] a;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready before cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_sym = s; cmd_move = mv;
    a = head;
    if (wr && push) exp_q.push_back({a, s});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_wr = 1'($urandom); cmd_sym = 8'($urandom); cmd_move = 2'($urandom);
    cyc = 0; wrc = int'(wr_en); wpc = int'(wrap);
    while (!cmd_ready && cyc < 100) begin
      if (wr_en) begin
        chk("wr_addr stable", int'(wr_addr), int'(a));
        chk("wr_data stable", int'(wr_data), int'(s));
      end
      @(posedge clk); #1;
      cyc++;
      wrc += int'(wr_en);
      wpc += int'(wrap);
    end
  endtask

  typedef struct {
    logic wr; logic [7:0] s; logic [1:0] mv;
    logic [2:0] h; logic w; logic wl; bit cs; logic [7:0] rs;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic wr, logic [7:0] s, logic [1:0] mv, logic [2:0] h,
                              logic w, logic wl, bit cs, logic [7:0] rs);
    vec_t v;
    v.wr = wr; v.s = s; v.mv = mv; v.h = h; v.w = w; v.wl = wl; v.cs = cs; v.rs = rs;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, wrc, wpc, n, acc;
    logic was_rdy, prev_en;
    logic [2:0] prev_a;
    logic [7:0] prev_d;

    // write 5A, readback, walk to 7, wrap both ways, then write 10..17 and read back leftwards
    add(1'b1, 8'h5A, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b0, 8'h00, 2'b10, 3'd0, 1'b0, 1'b0, 1'b1, 8'h5A);
    add(1'b0, 8'h00, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b0, 8'h00, 2'b11, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int h = 2; h < 8; h++) add(1'b0, 8'h00, 2'b01, 3'(h), 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b0, 8'h00, 2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    add(1'b0, 8'h00, 2'b10, 3'd7, 1'b1, 1'b1, 1'b0, 8'h00);
    add(1'b1, 8'h3C, 2'b00, 3'd7, 1'b0, 1'b1, 1'b1, 8'h3C);
    add(1'b0, 8'h00, 2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(1'b1, 8'(8'h10 + i), 2'b01, 3'(i + 1), 1'(i == 7), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(1'b0, 8'h00, 2'b10, 3'(7 - i), 1'(i == 0), 1'b1, 1'b1, 8'(8'h17 - i));

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_sym = 8'h00; cmd_move = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("reset head", int'(head), 0);
    chk("reset wr_en", int'(wr_en), 0);
    chk("reset wr_addr", int'(wr_addr), 0);
    chk("reset wr_data", int'(wr_data), 0);
    chk("reset wrap", int'(wrap), 0);
    chk("reset wrap_left", int'(wrap_left), 0);
    chk("reset err", int'(err), 0);
    chk("reset ready", int'(cmd_ready), 1);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].wr, vecs[i].s, vecs[i].mv, 1'b1, cyc, wrc, wpc);
      // write: 3 REQ + 2 REL + 1 MOVE edges; move-only: one MOVE edge after accept
      chk($sformatf("v%0d busy edges", i), cyc, vecs[i].wr ? 6 : 1);
      chk($sformatf("v%0d wr_en cycles", i), wrc, vecs[i].wr ? 3 : 0);
      chk($sformatf("v%0d wrap pulses", i), wpc, int'(vecs[i].w));
      chk($sformatf("v%0d head", i), int'(head), int'(vecs[i].h));
      chk($sformatf("v%0d wrap_left", i), int'(wrap_left), int'(vecs[i].wl));
      if (vecs[i].cs) chk($sformatf("v%0d sym", i), int'(sym), int'(vecs[i].rs));
      drain($sformatf("v%0d", i));
    end

    // responder never acks: abort after TIMEOUT cycles in REQ, head stays at 0
    no_ack = 1'b1;
    run_cmd(1'b1, 8'h99, 2'b01, 1'b0, cyc, wrc, wpc);
    chk("tmo busy edges", cyc, 15);
    chk("tmo wr_en cycles", wrc, 15);
    chk("tmo err", int'(err), 1);
    chk("tmo wr_en", int'(wr_en), 0);
    chk("tmo head", int'(head), 0);
    chk("tmo wrap pulses", wpc, 0);
    chk("tmo cell0", int'(mem[0]), 8'h10);
    no_ack = 1'b0;
    run_cmd(1'b0, 8'h00, 2'b01, 1'b1, cyc, wrc, wpc);
    chk("post-tmo head", int'(head), 1);
    chk("post-tmo err sticky", int'(err), 1);
    run_cmd(1'b1, 8'h77, 2'b00, 1'b1, cyc, wrc, wpc);
    chk("post-tmo write busy", cyc, 6);
    chk("post-tmo sym", int'(sym), 8'h77);
    drain("post-tmo");

    // stale ack present on REQ entry must not complete the handshake
    @(negedge clk);
    force_done = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_sym = 8'h5C; cmd_move = 2'b01;
    exp_q.push_back({head, 8'h5C});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stale wr_en held", int'(wr_en), 1);
    chk("stale busy", int'(cmd_ready), 0);
    @(negedge clk); force_done = 1'b0;
    n = 0;
    while (!cmd_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("stale ready", int'(cmd_ready), 1);
    chk("stale head", int'(head), 2);
    drain("stale");

    // valid held high across three back-to-back commands
    exp_q.push_back({3'd2, 8'hA1});
    exp_q.push_back({3'd3, 8'hB2});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_sym = 8'hA1; cmd_move = 2'b01;
    acc = 0; prev_en = 1'b0; prev_a = 3'd0; prev_d = 8'h00;
    for (int c = 0; c < 40 && acc < 3; c++) begin
      was_rdy = cmd_ready;
      @(posedge clk); #1;
      if (was_rdy) begin
        acc++;
        if (acc == 1) begin cmd_wr = 1'b1; cmd_sym = 8'hB2; cmd_move = 2'b00; end
        else if (acc == 2) begin cmd_wr = 1'b0; cmd_sym = 8'hC3; cmd_move = 2'b10; end
        else cmd_valid = 1'b0;
      end
      if (wr_en && prev_en) begin
        chk("b2b wr_addr stable", int'(wr_addr), int'(prev_a));
        chk("b2b wr_data stable", int'(wr_data), int'(prev_d));
      end
      prev_en = wr_en; prev_a = wr_addr; prev_d = wr_data;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b accepts", acc, 3);
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b head", int'(head), 2);
    chk("b2b sym", int'(sym), 8'hA1);
    drain("b2b");

    // async reset while in REQ
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_sym = 8'hEE; cmd_move = 2'b01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rst pre wr_en", int'(wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst head", int'(head), 0);
    chk("rst ready", int'(cmd_ready), 1);
    chk("rst err", int'(err), 0);
    chk("rst wr_data", int'(wr_data), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst no write", act_q.size(), 0);
    chk("rst cell2", int'(mem[2]), 8'hA1);
    chk("rst wr_en after", int'(wr_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
